// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter in front of the regfile write port.
// Two writeback requesters (ALU on req0, load on req1) share we3/wa3/wd3
// through a round-robin grant. A per-register scoreboard tracks
// destinations reserved by issue until their write commits, and flags
// RAW hazards for the instruction currently in issue.
module regfile_wb_arbiter #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 64
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            req0_valid,
    input  logic [AW-1:0]   req0_addr,
    input  logic [DW-1:0]   req0_data,
    output logic            req0_ready,

    input  logic            req1_valid,
    input  logic [AW-1:0]   req1_addr,
    input  logic [DW-1:0]   req1_data,
    output logic            req1_ready,

    input  logic            rsv_valid,
    input  logic [AW-1:0]   rsv_addr,
    output logic            rsv_ready,

    input  logic [AW-1:0]   chk_ra1,
    input  logic [AW-1:0]   chk_ra2,
    output logic            hazard,

    output logic            we3,
    output logic [AW-1:0]   wa3,
    output logic [DW-1:0]   wd3,

    output logic [NREG-1:0] pending
);

    // Highest register index is the zero register; writes to it are dropped.
    localparam logic [AW-1:0] XZR = AW'(NREG - 1);

    // 1 = req1 was granted last, so req0 wins the next tie.
    logic            last_grant;

    logic            grant0_c;
    logic            grant1_c;
    logic            grant_any_c;
    logic [AW-1:0]   win_addr_c;
    logic [DW-1:0]   win_data_c;
    logic            win_real_c;
    logic            rsv_take_c;
    logic [NREG-1:0] pending_nxt_c;

    // Round-robin grant: a lone requester always wins, a tie goes to the
    // requester that did not win last time.
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0_c = last_grant;
            grant1_c = ~last_grant;
        end else begin
            grant0_c = req0_valid;
            grant1_c = req1_valid;
        end
    end

    assign req0_ready  = grant0_c;
    assign req1_ready  = grant1_c;
    assign grant_any_c = grant0_c | grant1_c;

    // Select the winning payload; an xzr destination is accepted but not written.
    always_comb begin
        win_addr_c = req0_addr;
        win_data_c = req0_data;
        if (grant1_c) begin
            win_addr_c = req1_addr;
            win_data_c = req1_data;
        end
        win_real_c = grant_any_c && (win_addr_c != XZR);
    end

    // Remember who won last; idle cycles leave the history untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
        end else if (grant0_c) begin
            last_grant <= 1'b0;
        end else if (grant1_c) begin
            last_grant <= 1'b1;
        end
    end

    // Registered regfile write port; address/data hold when nothing is written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we3 <= 1'b0;
            wa3 <= '0;
            wd3 <= '0;
        end else begin
            we3 <= win_real_c;
            if (win_real_c) begin
                wa3 <= win_addr_c;
                wd3 <= win_data_c;
            end
        end
    end

    // A reservation must wait while its register still has an outstanding
    // write, including the cycle in which that write is committing.
    assign rsv_ready  = ~pending[rsv_addr] | (rsv_addr == XZR);
    assign rsv_take_c = rsv_valid & rsv_ready & (rsv_addr != XZR);

    // RAW check for both sources of the instruction in issue.
    assign hazard = (pending[chk_ra1] & (chk_ra1 != XZR))
                  | (pending[chk_ra2] & (chk_ra2 != XZR));

    // Scoreboard update: commit clears, reservation sets, set applied last so it wins.
    always_comb begin
        pending_nxt_c = pending;
        if (we3) begin
            pending_nxt_c[wa3] = 1'b0;
        end
        if (rsv_take_c) begin
            pending_nxt_c[rsv_addr] = 1'b1;
        end
        pending_nxt_c[NREG-1] = 1'b0;
    end

    // Scoreboard register; reset discards every outstanding reservation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt_c;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter with a cycle-level
// behavioural model of grants, scoreboard and regfile contents.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, rsv_valid;
    logic [4:0]  req0_addr, req1_addr, rsv_addr, chk_ra1, chk_ra2;
    logic [63:0] req0_data, req1_data;
    logic        req0_ready, req1_ready, rsv_ready, hazard;
    logic        we3;
    logic [4:0]  wa3;
    logic [63:0] wd3;
    logic [31:0] pending;

    int tests = 0;
    int fails = 0;

    // Model state
    logic [31:0] m_pend;
    int          m_last;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [63:0] m_wd;
    logic [63:0] m_rf [32];
    int          m_g;

    // Regfile driven by the DUT write port; x31 is hardwired zero.
    logic [63:0] rf [32];

    regfile_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
        .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .hazard(hazard),
        .we3(we3), .wa3(wa3), .wd3(wd3), .pending(pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we3 && wa3 != 5'd31) rf[wa3] <= wd3;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_last = 1;
        m_we   = 1'b0;
        m_g    = -1;
    endtask

    // One clock: check combinational outputs, advance model, check registered outputs.
    task automatic tick();
        int          g;
        logic [4:0]  a;
        logic [63:0] d;
        logic        rok, hz;
        #1;
        g = -1;
        if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
        else if (req0_valid)          g = 0;
        else if (req1_valid)          g = 1;
        rok = (rsv_addr == 5'd31) || !m_pend[rsv_addr];
        hz  = (chk_ra1 != 5'd31 && m_pend[chk_ra1]) || (chk_ra2 != 5'd31 && m_pend[chk_ra2]);
        check("req0_ready", 64'(req0_ready), 64'(g == 0));
        check("req1_ready", 64'(req1_ready), 64'(g == 1));
        check("rsv_ready",  64'(rsv_ready),  64'(rok));
        check("hazard",     64'(hazard),     64'(hz));
        @(posedge clk);
        if (m_we) begin
            m_rf[m_wa]   = m_wd;
            m_pend[m_wa] = 1'b0;
        end
        if (rsv_valid && rok && rsv_addr != 5'd31) m_pend[rsv_addr] = 1'b1;
        m_we = 1'b0;
        if (g >= 0) begin
            m_last = g;
            a = (g == 1) ? req1_addr : req0_addr;
            d = (g == 1) ? req1_data : req0_data;
            if (a != 5'd31) begin
                m_we = 1'b1;
                m_wa = a;
                m_wd = d;
            end
        end
        m_g = g;
        #1;
        check("we3",     64'(we3),     64'(m_we));
        check("pending", 64'(pending), 64'(m_pend));
        if (m_we) begin
            check("wa3", 64'(wa3), 64'(m_wa));
            check("wd3", wd3, m_wd);
        end
        check($sformatf("rf[%0d]", chk_ra1), rf[chk_ra1], m_rf[chk_ra1]);
    endtask

    function automatic logic [4:0] rand_reg();
        return ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf[i]   = '0;
            m_rf[i] = '0;
        end
        reset = 1'b0;
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
        rsv_valid = 0; rsv_addr = 0; chk_ra1 = 0; chk_ra2 = 0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_we3", 64'(we3), 64'd0);
        check("rst_wa3", 64'(wa3), 64'd0);
        check("rst_wd3", wd3, 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        reset = 1'b1;

        // Idle: no hazard for any source register
        for (int i = 0; i < 32; i++) begin
            chk_ra1 = 5'(i);
            chk_ra2 = 5'(31 - i);
            tick();
        end
        chk_ra1 = 0; chk_ra2 = 0;

        // Single write to x5
        rsv_valid = 1; rsv_addr = 5'd5;
        tick();
        rsv_valid = 0;
        req0_valid = 1; req0_addr = 5'd5; req0_data = 64'd255; chk_ra1 = 5'd5;
        #1;
        check("sw_ready0", 64'(req0_ready), 64'd1);
        check("sw_hazard", 64'(hazard), 64'd1);
        tick();
        req0_valid = 0;
        check("sw_we3", 64'(we3), 64'd1);
        check("sw_wa3", 64'(wa3), 64'd5);
        check("sw_wd3", wd3, 64'd255);
        check("sw_pend5_n1", 64'(pending[5]), 64'd1);
        tick();
        check("sw_pend5_n2", 64'(pending[5]), 64'd0);
        check("sw_rf5", rf[5], 64'd255);
        check("sw_hazard_gone", 64'(hazard), 64'd0);

        // Asynchronous reset while a write is in flight
        rsv_valid = 1; rsv_addr = 5'd6;
        tick();
        rsv_valid = 0;
        req0_valid = 1; req0_addr = 5'd6; req0_data = 64'h1234;
        tick();
        req0_valid = 0;
        check("ar_we3_before", 64'(we3), 64'd1);
        #1 reset = 1'b0;
        #1;
        check("ar_we3", 64'(we3), 64'd0);
        check("ar_pending", 64'(pending), 64'd0);
        check("ar_wa3", 64'(wa3), 64'd0);
        model_reset();
        #1 reset = 1'b1;
        tick();
        check("ar_rf6_discarded", rf[6], 64'd0);

        // Contention: grants alternate starting with req0
        req0_valid = 1; req0_addr = 5'd1; req0_data = 64'h11;
        req1_valid = 1; req1_addr = 5'd2; req1_data = 64'h22;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("ct_grant%0d", c), 64'(m_g), 64'(c % 2));
            if (m_g == 0) begin req0_addr = 5'(3 + c); req0_data = 64'(c + 100); end
            if (m_g == 1) begin req1_addr = 5'(3 + c); req1_data = 64'(c + 200); end
        end
        req0_valid = 0; req1_valid = 0;
        tick();

        // xzr write and reservation
        req1_valid = 1; req1_addr = 5'd31; req1_data = 64'hc0c0;
        #1;
        check("xz_ready1", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 0;
        check("xz_we3", 64'(we3), 64'd0);
        rsv_valid = 1; rsv_addr = 5'd31;
        #1;
        check("xz_rsv_ready", 64'(rsv_ready), 64'd1);
        tick();
        rsv_valid = 0;
        check("xz_pending", 64'(pending), 64'd0);
        check("xz_rf31", rf[31], 64'd0);

        // Hazards and WAW stall
        rsv_valid = 1; rsv_addr = 5'd7;
        tick();
        chk_ra1 = 5'd7; chk_ra2 = 5'd0;
        #1;
        check("hz_ra1_7", 64'(hazard), 64'd1);
        chk_ra1 = 5'd0; chk_ra2 = 5'd25;
        #1;
        check("hz_ra2_25", 64'(hazard), 64'd0);
        chk_ra1 = 5'd7;
        #1;
        check("hz_waw_stall", 64'(rsv_ready), 64'd0);
        req1_valid = 1; req1_addr = 5'd7; req1_data = 64'hbeef;
        tick();
        req1_valid = 0;
        check("hz_stall_commit_cycle", 64'(rsv_ready), 64'd0);
        tick();
        check("hz_after_commit_rsv", 64'(rsv_ready), 64'd1);
        check("hz_after_commit_haz", 64'(hazard), 64'd0);
        check("hz_rf7", rf[7], 64'hbeef);
        tick();
        check("hz_rsv7_set", 64'(pending[7]), 64'd1);
        rsv_valid = 0; chk_ra1 = 0; chk_ra2 = 0;
        req0_valid = 1; req0_addr = 5'd7; req0_data = 64'h77;
        tick();
        req0_valid = 0;
        tick();

        // Set/clear collision on x9
        rsv_valid = 1; rsv_addr = 5'd9;
        tick();
        rsv_valid = 0;
        req0_valid = 1; req0_addr = 5'd9; req0_data = 64'h99;
        tick();
        req0_valid = 0;
        rsv_valid = 1; rsv_addr = 5'd9;
        #1;
        check("co_we3", 64'(we3), 64'd1);
        check("co_rsv_blocked", 64'(rsv_ready), 64'd0);
        tick();
        check("co_pend9_clear", 64'(pending[9]), 64'd0);
        check("co_retry_ready", 64'(rsv_ready), 64'd1);
        tick();
        rsv_valid = 0;
        check("co_pend9_set", 64'(pending[9]), 64'd1);

        // Randomized traffic; requesters hold their payload until accepted
        for (int c = 0; c < 400; c++) begin
            if (!req0_valid && $urandom_range(0, 2) != 0) begin
                req0_valid = 1; req0_addr = rand_reg(); req0_data = {$urandom, $urandom};
            end
            if (!req1_valid && $urandom_range(0, 2) != 0) begin
                req1_valid = 1; req1_addr = rand_reg(); req1_data = {$urandom, $urandom};
            end
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_addr  = rand_reg();
            chk_ra1   = rand_reg();
            chk_ra2   = rand_reg();
            tick();
            if (m_g == 0) req0_valid = 0;
            if (m_g == 1) req1_valid = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
